// File: rtl/ro_sampler_pkg.sv
// Shared types and constants for the ring-oscillator sampler: measurement
// FSM states, random-byte width and synchronizer depth.
package ro_sampler_pkg;

   localparam int RND_BYTE_W  = 8;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } meas_state_e;

endpackage

// File: rtl/ro_sync_edge.sv
// One oscillator channel: SYNC_STAGES-deep synchronizer followed by a history
// flop so that a rising edge is reported as sync==1 && prev==0.
module ro_sync_edge
   import ro_sampler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // synchronizer chain plus edge-history flop
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign sync = sync_r[SYNC_STAGES-1];
   assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/ro_sampler.sv
// Ring-oscillator sampler: gated edge-count frequency measurement on one
// channel, plus an independent entropy collector producing random bytes.
module ro_sampler
   import ro_sampler_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         osc_in,
   input  logic [$clog2(N_CH)-1:0] ch_sel,
   input  logic [WIN_W-1:0]        win_len,
   input  logic                    start,
   output logic                    busy,
   output logic [CNT_W-1:0]        count,
   output logic                    count_valid,
   output logic                    count_sat,
   input  logic                    rnd_en,
   input  logic                    rnd_mix,
   input  logic                    rnd_debias,
   output logic [RND_BYTE_W-1:0]   rnd_byte,
   output logic                    rnd_valid,
   input  logic                    rnd_ready,
   output logic                    rnd_ovf
);

   localparam int CH_W   = $clog2(N_CH);
   localparam int FILL_W = $clog2(RND_BYTE_W);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
   localparam logic [FILL_W-1:0] FILL_TOP = FILL_W'(RND_BYTE_W - 1);

   logic [N_CH-1:0] sync_s;
   logic [N_CH-1:0] rise_s;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ro_sync_edge u_sync (
         .clk  (clk),
         .rst  (rst),
         .d    (osc_in[g]),
         .sync (sync_s[g]),
         .rise (rise_s[g])
      );
   end

   meas_state_e      state_r;
   logic [CH_W-1:0]  ch_r;
   logic [WIN_W-1:0] win_ld_r;
   logic [WIN_W-1:0] win_cnt_r;
   logic [CNT_W-1:0] edge_cnt_r;
   logic             sat_r;
   logic             busy_r;
   logic [CNT_W-1:0] count_r;
   logic             count_valid_r;
   logic             count_sat_r;

   // measurement FSM with registered status/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         ch_r          <= '0;
         win_ld_r      <= '0;
         win_cnt_r     <= '0;
         edge_cnt_r    <= '0;
         sat_r         <= 1'b0;
         busy_r        <= 1'b0;
         count_r       <= '0;
         count_valid_r <= 1'b0;
         count_sat_r   <= 1'b0;
      end else begin
         count_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  ch_r     <= ch_sel;
                  win_ld_r <= (win_len == '0) ? WIN_ONE : win_len;
                  busy_r   <= 1'b1;
                  state_r  <= ST_ARM;
               end
            end
            ST_ARM: begin
               win_cnt_r  <= win_ld_r;
               edge_cnt_r <= '0;
               sat_r      <= 1'b0;
               state_r    <= ST_GATE;
            end
            ST_GATE: begin
               // an edge arriving at full scale is lost, so flag saturation
               if (rise_s[ch_r]) begin
                  if (edge_cnt_r == CNT_MAX) begin
                     sat_r <= 1'b1;
                  end else begin
                     edge_cnt_r <= edge_cnt_r + CNT_ONE;
                  end
               end
               win_cnt_r <= win_cnt_r - WIN_ONE;
               if (win_cnt_r == WIN_ONE) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               count_r       <= edge_cnt_r;
               count_sat_r   <= sat_r;
               count_valid_r <= 1'b1;
               busy_r        <= 1'b0;
               state_r       <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   logic                  pair_r;
   logic                  first_r;
   logic [RND_BYTE_W-1:0] acc_r;
   logic [FILL_W-1:0]     fill_r;
   logic [RND_BYTE_W-1:0] rnd_byte_r;
   logic                  rnd_valid_r;
   logic                  rnd_ovf_r;

   logic                  sample_s;
   logic                  emit_s;
   logic                  bit_s;
   logic [RND_BYTE_W-1:0] byte_s;
   logic                  full_s;
   logic                  hs_s;

   // entropy sample selection, von Neumann pairing and byte-complete decode
   always_comb begin
      sample_s = 1'b0;
      emit_s   = 1'b0;
      bit_s    = 1'b0;
      if (rnd_mix) begin
         sample_s = ^sync_s;
      end else begin
         sample_s = sync_s[ch_sel];
      end
      if (!rnd_en) begin
         emit_s = 1'b0;
         bit_s  = 1'b0;
      end else if (!rnd_debias) begin
         emit_s = 1'b1;
         bit_s  = sample_s;
      end else if (pair_r) begin
         emit_s = first_r ^ sample_s;
         bit_s  = first_r;
      end else begin
         emit_s = 1'b0;
         bit_s  = 1'b0;
      end
      byte_s = {bit_s, acc_r[RND_BYTE_W-1:1]};
      full_s = emit_s && (fill_r == FILL_TOP);
      hs_s   = rnd_valid_r && rnd_ready;
   end

   // accumulator, holding register and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_r      <= 1'b0;
         first_r     <= 1'b0;
         acc_r       <= '0;
         fill_r      <= '0;
         rnd_byte_r  <= '0;
         rnd_valid_r <= 1'b0;
         rnd_ovf_r   <= 1'b0;
      end else begin
         if (!rnd_en) begin
            pair_r <= 1'b0;
            fill_r <= '0;
         end else begin
            if (rnd_debias) begin
               pair_r <= ~pair_r;
               if (!pair_r) begin
                  first_r <= sample_s;
               end
            end else begin
               pair_r <= 1'b0;
            end
            if (full_s) begin
               acc_r  <= '0;
               fill_r <= '0;
            end else if (emit_s) begin
               acc_r  <= byte_s;
               fill_r <= fill_r + FILL_ONE;
            end
         end
         // a consumer handshake in the completing cycle frees the holding register
         if (full_s) begin
            if (!rnd_valid_r || hs_s) begin
               rnd_byte_r  <= byte_s;
               rnd_valid_r <= 1'b1;
            end else begin
               rnd_ovf_r <= 1'b1;
            end
         end else if (hs_s) begin
            rnd_valid_r <= 1'b0;
         end
      end
   end

   assign busy        = busy_r;
   assign count       = count_r;
   assign count_valid = count_valid_r;
   assign count_sat   = count_sat_r;
   assign rnd_byte    = rnd_byte_r;
   assign rnd_valid   = rnd_valid_r;
   assign rnd_ovf     = rnd_ovf_r;

endmodule

// File: tb/tb_ro_sampler.sv
// Scoreboard bench for ro_sampler: stimulus pushes expected results, a
// negedge monitor pops and compares on count_valid / rnd handshakes.
module tb_ro_sampler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  ch_sel = 3'd0;
   logic [15:0] win_len = 16'd0;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic        rnd_en = 1'b0;
   logic        rnd_mix = 1'b0;
   logic        rnd_debias = 1'b0;
   logic        rnd_ready = 1'b0;
   logic        osc_gen = 1'b0;
   logic        force_en = 1'b0;
   logic [7:0]  force_val = 8'h00;
   logic [7:0]  osc_in;
   int          osc_half = 0;
   int          osc_ph = 0;

   logic        busy, count_valid, count_sat, rnd_valid, rnd_ovf;
   logic [15:0] count;
   logic [7:0]  rnd_byte;
   logic        busy4, count_valid4, count_sat4, rnd_valid4, rnd_ovf4;
   logic [3:0]  count4;
   logic [7:0]  rnd_byte4;

   typedef struct { int lo; int hi; int sat; int cyc; } meas_t;
   typedef struct { string name; int act; int exp; } chk_t;

   meas_t      meas_q[$];
   meas_t      meas4_q[$];
   logic [7:0] rnd_q[$];
   chk_t       chk_q[$];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   meas_t      mon_m;
   chk_t       mon_c;
   logic [7:0] mon_b;

   assign osc_in = force_en ? force_val : {4'b0000, osc_gen, 3'b000};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ro_sampler dut (
      .clk(clk), .rst(rst), .osc_in(osc_in), .ch_sel(ch_sel), .win_len(win_len),
      .start(start), .busy(busy), .count(count), .count_valid(count_valid),
      .count_sat(count_sat), .rnd_en(rnd_en), .rnd_mix(rnd_mix),
      .rnd_debias(rnd_debias), .rnd_byte(rnd_byte), .rnd_valid(rnd_valid),
      .rnd_ready(rnd_ready), .rnd_ovf(rnd_ovf)
   );

   ro_sampler #(.N_CH(8), .CNT_W(4), .WIN_W(16)) dut4 (
      .clk(clk), .rst(rst), .osc_in(osc_in), .ch_sel(ch_sel), .win_len(win_len),
      .start(start4), .busy(busy4), .count(count4), .count_valid(count_valid4),
      .count_sat(count_sat4), .rnd_en(1'b0), .rnd_mix(1'b0),
      .rnd_debias(1'b0), .rnd_byte(rnd_byte4), .rnd_valid(rnd_valid4),
      .rnd_ready(1'b0), .rnd_ovf(rnd_ovf4)
   );

   // free-running oscillator model on channel 3
   initial begin
      forever begin
         @(posedge clk); #1;
         if (osc_half != 0) begin
            if (osc_ph >= osc_half - 1) begin
               osc_ph  = 0;
               osc_gen = ~osc_gen;
            end else begin
               osc_ph++;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // monitor: the only process that compares and updates the counters
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         mon_c = chk_q.pop_front();
         chk(mon_c.name, mon_c.act, mon_c.exp);
      end
      if (count_valid) begin
         if (meas_q.size() == 0) begin
            chk("count_valid_unexpected", 1, 0);
         end else begin
            mon_m = meas_q.pop_front();
            chk_range("count", int'(count), mon_m.lo, mon_m.hi);
            chk("count_sat", int'(count_sat), mon_m.sat);
            chk("count_latency_cyc", cyc, mon_m.cyc);
         end
      end
      if (count_valid4) begin
         if (meas4_q.size() == 0) begin
            chk("count4_valid_unexpected", 1, 0);
         end else begin
            mon_m = meas4_q.pop_front();
            chk_range("count4", int'(count4), mon_m.lo, mon_m.hi);
            chk("count4_sat", int'(count_sat4), mon_m.sat);
            chk("count4_latency_cyc", cyc, mon_m.cyc);
         end
      end
      if (rnd_valid && rnd_ready) begin
         if (rnd_q.size() == 0) begin
            chk("rnd_handshake_unexpected", int'(rnd_byte), -1);
         end else begin
            mon_b = rnd_q.pop_front();
            chk("rnd_byte_hs", int'(rnd_byte), int'(mon_b));
         end
      end
   end

   task automatic push_chk(input string name, input int act, input int exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endtask

   task automatic wait_idle(input int which, input int lim);
      bit done = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if ((which == 0) ? !busy : !busy4) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) push_chk("idle_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_meas(input int which, input int w, input int lo, input int hi, input int sat);
      meas_t m;
      @(posedge clk); #1;
      ch_sel  = 3'd3;
      win_len = 16'(w);
      m.lo  = lo;
      m.hi  = hi;
      m.sat = sat;
      m.cyc = cyc + ((w == 0) ? 1 : w) + 3;
      if (which == 0) begin
         meas_q.push_back(m);
         start = 1'b1;
      end else begin
         meas4_q.push_back(m);
         start4 = 1'b1;
      end
      @(posedge clk); #1;
      start  = 1'b0;
      start4 = 1'b0;
      wait_idle(which, w + 20);
   endtask

   task automatic rnd_stream(input logic [31:0] bits, input int nsamp, input logic deb,
                             input logic mix, input int chan);
      rnd_debias = deb;
      rnd_mix    = mix;
      for (int t = 0; t < nsamp + 2; t++) begin
         @(posedge clk); #1;
         force_val = mix ? 8'hC0 : 8'h00;
         if (t < nsamp) force_val[chan] = bits[t];
         rnd_en = (t >= 2);
      end
      @(posedge clk); #1;
      rnd_en = 1'b0;
   endtask

   initial begin
      meas_t m;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      push_chk("rst_busy", int'(busy), 0);
      push_chk("rst_count", int'(count), 0);
      push_chk("rst_count_valid", int'(count_valid), 0);
      push_chk("rst_count_sat", int'(count_sat), 0);
      push_chk("rst_rnd_byte", int'(rnd_byte), 0);
      push_chk("rst_rnd_valid", int'(rnd_valid), 0);
      push_chk("rst_rnd_ovf", int'(rnd_ovf), 0);
      push_chk("rst_busy4", int'(busy4), 0);

      // win_len=0 gates one cycle; extra start pulses while busy are ignored
      osc_half = 5;
      repeat (10) @(posedge clk);
      #1;
      ch_sel  = 3'd3;
      win_len = 16'd0;
      m.lo = 0; m.hi = 1; m.sat = 0; m.cyc = cyc + 4;
      meas_q.push_back(m);
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      repeat (12) @(negedge clk);
      push_chk("win0_busy_after", int'(busy), 0);

      // stopped oscillator counts nothing
      osc_half = 0;
      repeat (8) @(posedge clk);
      do_meas(0, 5, 0, 0, 0);

      // period 10 over a 100-cycle window
      osc_half = 5;
      repeat (3) @(posedge clk);
      do_meas(0, 100, 9, 11, 0);

      // 4-bit counter saturates with ~50 edges
      osc_half = 2;
      do_meas(1, 200, 15, 15, 1);
      osc_half = 0;

      // debiased 0,1,1,0 stream: two AA bytes, second dropped
      @(posedge clk); #1;
      force_en  = 1'b1;
      rnd_ready = 1'b0;
      ch_sel    = 3'd3;
      rnd_q.push_back(8'hAA);
      rnd_stream(32'h6666_6666, 32, 1'b1, 1'b0, 3);
      @(negedge clk);
      push_chk("deb_held_valid", int'(rnd_valid), 1);
      push_chk("deb_held_byte", int'(rnd_byte), 8'hAA);
      push_chk("deb_ovf", int'(rnd_ovf), 1);
      @(posedge clk); #1;
      rnd_ready = 1'b1;
      repeat (3) @(negedge clk);
      push_chk("hs_clears_valid", int'(rnd_valid), 0);

      // raw XOR-mix and raw single-channel bytes
      rnd_q.push_back(8'h5C);
      rnd_stream(32'h0000_005C, 8, 1'b0, 1'b1, 5);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      ch_sel = 3'd2;
      rnd_q.push_back(8'hC3);
      rnd_stream(32'h0000_00C3, 8, 1'b0, 1'b0, 2);
      repeat (3) @(negedge clk);
      push_chk("raw_valid_after_hs", int'(rnd_valid), 0);

      // reset during GATE aborts without a count_valid
      force_en = 1'b0;
      osc_half = 5;
      @(posedge clk); #1;
      ch_sel  = 3'd3;
      win_len = 16'd50;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      push_chk("gate_busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      push_chk("abort_busy", int'(busy), 0);
      push_chk("abort_count", int'(count), 0);
      push_chk("abort_count_valid", int'(count_valid), 0);
      push_chk("abort_count_sat", int'(count_sat), 0);
      push_chk("abort_rnd_byte", int'(rnd_byte), 0);
      push_chk("abort_rnd_valid", int'(rnd_valid), 0);
      push_chk("abort_rnd_ovf", int'(rnd_ovf), 0);
      repeat (70) @(negedge clk);

      push_chk("meas_q_drained", meas_q.size(), 0);
      push_chk("meas4_q_drained", meas4_q.size(), 0);
      push_chk("rnd_q_drained", rnd_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ro_sampler.md
RO_SAMPLER -- requirements
Module: ro_sampler

Interface
REQ-001 The module SHALL have parameter N_CH, default 8, number of oscillator input channels (2..16).
REQ-002 The module SHALL have parameter CNT_W, default 16, edge-counter result width.
REQ-003 The module SHALL have parameter WIN_W, default 16, gate-window length width.
REQ-004 Port clk, input, 1: sole clock; every flop in the block is on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port osc_in, input, N_CH: free-running ring-oscillator outputs, asynchronous to clk.
REQ-007 Port ch_sel, input, $clog2(N_CH): channel to measure or sample; sampled on start and on each entropy sample.
REQ-008 Port win_len, input, WIN_W: gate window in clk cycles; sampled on start.
REQ-009 Port start, input, 1: single-cycle request to begin a frequency measurement.
REQ-010 Port busy, output, 1: high while a measurement is in progress.
REQ-011 Port count, output, CNT_W: latched edge count of the last completed measurement.
REQ-012 Port count_valid, output, 1: one-cycle pulse when count updates.
REQ-013 Port count_sat, output, 1: the last measurement saturated; valid with count.
REQ-014 Port rnd_en, input, 1: enables entropy collection.
REQ-015 Port rnd_mix, input, 1: 1 = XOR of all channels; 0 = channel ch_sel only.
REQ-016 Port rnd_debias, input, 1: 1 = von Neumann debiasing; 0 = raw bits.
REQ-017 Port rnd_byte, output, 8: random byte holding register.
REQ-018 Port rnd_valid, output, 1: rnd_byte holds an unconsumed byte.
REQ-019 Port rnd_ready, input, 1: consumer accepts rnd_byte when rnd_valid && rnd_ready.
REQ-020 Port rnd_ovf, output, 1: sticky; a completed byte was dropped.

Function
REQ-021 Each osc_in bit SHALL pass a 2-flop synchronizer plus a third flop for edge detect; a rising edge is sync==1 && prev==0.
REQ-022 Measurement FSM states SHALL be IDLE, ARM, GATE, DONE.
REQ-023 IDLE->ARM on start; start is ignored in every other state.
REQ-024 ARM (1 cycle): latch ch_sel, load the window counter with max(win_len,1), clear the edge counter and saturation flag.
REQ-025 GATE: count rising edges of the latched channel each cycle and decrement the window counter; leave GATE when the window counter reaches 1, so GATE lasts exactly max(win_len,1) cycles.
REQ-026 The edge counter SHALL saturate at 2^CNT_W-1 and set the saturation flag; it SHALL NOT wrap.
REQ-027 DONE (1 cycle): load count and count_sat and pulse count_valid; next state IDLE.
REQ-028 busy=1 in ARM, GATE and DONE; start-to-count_valid latency is max(win_len,1)+2 cycles.
REQ-029 With rnd_en=1, take one entropy sample per cycle: the selected synchronized bit, or the XOR of all synchronized bits when rnd_mix=1.
REQ-030 With rnd_debias=1, pair consecutive samples: 01 emits 0, 10 emits 1, 00/11 emit nothing. With rnd_debias=0, every sample emits a bit.
REQ-031 Emitted bits SHALL shift LSB-first into an 8-bit accumulator with a 3-bit fill count.
REQ-032 On the 8th bit, if rnd_valid=0 or a handshake occurs that same cycle, load rnd_byte and set rnd_valid; otherwise drop the byte and set rnd_ovf.
REQ-033 In both cases of REQ-032 the accumulator SHALL restart empty.
REQ-034 A handshake with no new byte clears rnd_valid; rnd_byte stays stable while rnd_valid=1.
REQ-035 rnd_en=0 SHALL clear the pair phase and fill count; rnd_valid and rnd_byte are unaffected.
REQ-036 Measurement and entropy paths SHALL run concurrently and independently.

Reset
REQ-037 rst SHALL force: FSM=IDLE, busy=0, count=0, count_valid=0, count_sat=0, rnd_byte=0, rnd_valid=0, rnd_ovf=0, accumulator/fill/pair state=0, synchronizer flops=0.
REQ-038 rst asserted mid-measurement SHALL abort it with no count_valid pulse.
REQ-039 rst has priority over start and over the rnd handshake in the same cycle.
REQ-040 rnd_ovf SHALL clear only on rst.

Structure
REQ-041 Package ro_sampler_pkg SHALL hold the FSM state enum and the constants RND_BYTE_W=8 and SYNC_STAGES=2.
REQ-042 Sub-module ro_sync_edge (synchronizer + rising-edge detect, one channel) SHALL be instantiated N_CH times.

Verification
REQ-043 The bench SHALL cover: osc_in[3] toggling at period 10 clk, ch_sel=3, win_len=100, start -> count_valid exactly 102 cycles after start, count=10 (+/-1), count_sat=0.
REQ-044 The bench SHALL cover: CNT_W=4, osc period 4 clk, win_len=200 -> count=15, count_sat=1.
REQ-045 The bench SHALL cover: win_len=0 -> GATE lasts 1 cycle; start pulsed again while busy -> exactly one count_valid.
REQ-046 The bench SHALL cover: rnd_debias=1 with the selected synchronized bit forced to the pattern 0,1,1,0 repeating -> bits 0,1,... and rnd_byte=8'hAA after 16 samples.
REQ-047 The bench SHALL cover: rnd_ready=0 with two bytes completed -> first byte held, rnd_ovf=1; rnd_ready=1 -> handshake clears rnd_valid.
REQ-048 The bench SHALL cover: rst asserted during GATE -> busy=0 the next cycle, no count_valid, all outputs at their reset values.
